// File: rtl/if_id_buffer.sv
// IF->ID pipeline register: realigns the registered BRAM word with its PC,
// parks the fetched word in a one-entry skid across stalls, and squashes on flush.
module if_id_buffer #(
    parameter int                     BUS_WIDTH   = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [BUS_WIDTH-1:0]   if_pc,
    input  logic [INSTR_WIDTH-1:0] if_instr,
    output logic [BUS_WIDTH-1:0]   id_pc,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic                   id_valid,
    output logic                   skid_full
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [BUS_WIDTH-1:0]   pc_d;
    logic                   pc_d_vld;
    logic [INSTR_WIDTH-1:0] skid;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc     <= '0;
            id_instr  <= NOP_INSTR;
            id_valid  <= 1'b0;
            pc_d      <= '0;
            pc_d_vld  <= 1'b0;
            skid      <= NOP_INSTR;
            state     <= RUN;
            skid_full <= 1'b0;
        end else if (flush) begin
            // The word landing next cycle is wrong-path too: pc_d_vld=0 drops it.
            id_instr  <= NOP_INSTR;
            id_valid  <= 1'b0;
            id_pc     <= pc_d;
            pc_d      <= if_pc;
            pc_d_vld  <= 1'b0;
            skid      <= NOP_INSTR;
            state     <= RUN;
            skid_full <= 1'b0;
        end else if (stall) begin
            // Only the first stall edge captures; later ones see re-read data.
            unique case (state)
                RUN: begin
                    skid      <= if_instr;
                    state     <= HOLD;
                    skid_full <= 1'b1;
                end
                HOLD: begin
                    skid      <= skid;
                    state     <= HOLD;
                    skid_full <= 1'b1;
                end
                default: begin
                    state     <= RUN;
                    skid_full <= 1'b0;
                end
            endcase
        end else begin
            unique case (state)
                HOLD:    id_instr <= skid;
                default: id_instr <= if_instr;
            endcase
            id_pc     <= pc_d;
            id_valid  <= pc_d_vld;
            pc_d      <= if_pc;
            pc_d_vld  <= 1'b1;
            state     <= RUN;
            skid_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: emulates IF + synchronous BRAM, applies a
// directed vector table and a hand-written back-to-back flush sequence.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [63:0] tgt;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid, skid_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_valid  (id_valid),
        .skid_full (skid_full)
    );

    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'h1000_0000 + a[31:0];
    endfunction

    // IF stage + BRAM: pc frozen by stall, redirected by flush.
    always_ff @(posedge clk) begin
        if_instr <= mem(if_pc);
        if (rst)        if_pc <= '0;
        else if (flush) if_pc <= tgt;
        else if (!stall) if_pc <= if_pc + 64'd4;
    end

    // mode 0: valid/skid only; 1: also pc+instr; 2: also instr
    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [63:0] tgt;
        logic [1:0]  mode;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        skid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, s, f, input logic [63:0] t,
                                input logic [1:0] m, input logic [63:0] p,
                                input logic [31:0] i, input logic v, k);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.tgt = t;
        x.mode = m; x.pc = p; x.instr = i; x.valid = v; x.skid = k;
        return x;
    endfunction

    task automatic check(input string name, input logic [1:0] m,
                         input logic [63:0] p, input logic [31:0] i,
                         input logic v, input logic k);
        logic ok;
        ok = (id_valid === v) && (skid_full === k);
        if (m == 2'd1) ok = ok && (id_pc === p) && (id_instr === i);
        if (m == 2'd2) ok = ok && (id_instr === i);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h valid=%b skid=%b want pc=%h instr=%h valid=%b skid=%b",
                     name, id_pc, id_instr, id_valid, skid_full, p, i, v, k);
        end
    endtask

    task automatic step(input logic r, s, f, input logic [63:0] t);
        rst = r; stall = s; flush = f; tgt = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; tgt = '0;

        // T1 reset
        repeat (3) vecs.push_back(mk(1, 0, 0, 0, 1, 64'h0, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, mem(64'h0), 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h4, mem(64'h4), 1, 0));
        // T2 single stall with pc_d=8
        vecs.push_back(mk(0, 1, 0, 0, 1, 64'h4, mem(64'h4), 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h8, mem(64'h8), 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'hc, mem(64'hc), 1, 0));
        // T3 five-cycle stall
        repeat (5) vecs.push_back(mk(0, 1, 0, 0, 1, 64'hc, mem(64'hc), 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h10, mem(64'h10), 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h14, mem(64'h14), 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h18, mem(64'h18), 1, 0));
        // T4 flush with if_pc=0x20, target 0x100
        vecs.push_back(mk(0, 0, 1, 64'h100, 2, 0, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h100, mem(64'h100), 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h104, mem(64'h104), 1, 0));
        // T5 stall into HOLD, then flush+stall
        vecs.push_back(mk(0, 1, 0, 0, 1, 64'h104, mem(64'h104), 1, 1));
        vecs.push_back(mk(0, 1, 1, 64'h200, 2, 0, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h200, mem(64'h200), 1, 0));
        // T6 reset while in HOLD
        vecs.push_back(mk(0, 1, 0, 0, 1, 64'h200, mem(64'h200), 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 64'h200, mem(64'h200), 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 64'h0, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, mem(64'h0), 1, 0));

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].stall, vecs[n].flush, vecs[n].tgt);
            check($sformatf("vec%0d", n), vecs[n].mode, vecs[n].pc,
                  vecs[n].instr, vecs[n].valid, vecs[n].skid);
        end

        // Back-to-back flushes: bubbles until two edges after the last one
        step(0, 0, 1, 64'h300);
        check("flush1", 2'd2, 0, NOP, 1'b0, 1'b0);
        step(0, 0, 1, 64'h300);
        check("flush2", 2'd2, 0, NOP, 1'b0, 1'b0);
        step(0, 0, 0, 0);
        check("flush_bubble", 2'd0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 0);
        check("flush_target", 2'd1, 64'h300, mem(64'h300), 1'b1, 1'b0);
        // Outputs must not move between edges
        @(negedge clk);
        check("stable_mid", 2'd1, 64'h300, mem(64'h300), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
